// File: rtl/floatb_inv.sv
`default_nettype none
// ============================================================================
// Module   : floatb_inv
// Brief    : Iterative FLOATB inverse: 11-bit float sample -> 16-bit linear.
// Revision : 1.0
// ============================================================================
module floatb_inv (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        srs,
  input  logic [3:0]  srexp,
  input  logic [5:0]  srmant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] sr,
  input  logic        scan_in0,
  input  logic        scan_in1,
  input  logic        scan_in2,
  input  logic        scan_in3,
  input  logic        scan_in4,
  input  logic        scan_enable,
  input  logic        test_mode,
  output logic        scan_out0,
  output logic        scan_out1,
  output logic        scan_out2,
  output logic        scan_out3,
  output logic        scan_out4
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_shift = 2'd1;
  localparam logic [1:0] c_st_done  = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [20:0] r_acc;
  logic [3:0]  r_cnt;
  logic        r_sgn;
  logic [15:0] r_sr;
  logic [14:0] w_mag;
  logic [15:0] w_result;

  // DFT pins are stitched at scan insertion; functionally they are inert.
  logic w_unused_dft;
  assign w_unused_dft = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                          scan_enable, test_mode};
  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= c_st_idle;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (in_valid)     w_state_nxt = c_st_shift;
      c_st_shift: if (r_cnt == 4'd0) w_state_nxt = c_st_done;
      c_st_done:  if (out_ready)    w_state_nxt = c_st_idle;
      default:                      w_state_nxt = c_st_idle;
    endcase
  end

  // Handshake outputs are pure decodes of the registered state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      c_st_idle: in_ready  = 1'b1;
      c_st_done: out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Dropping the 6 fractional mantissa bits truncates toward zero in magnitude.
  assign w_mag    = r_acc[20:6];
  assign w_result = r_sgn ? (16'd0 - {1'b0, w_mag}) : {1'b0, w_mag};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_sgn <= 1'b0;
      r_sr  <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (in_valid) begin
            r_acc <= {15'd0, srmant};
            r_cnt <= srexp;
            r_sgn <= srs;
          end
        end
        c_st_shift: begin
          if (r_cnt != 4'd0) begin
            r_acc <= {r_acc[19:0], 1'b0};
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_sr <= w_result;
          end
        end
        default: ;
      endcase
    end
  end

  assign sr = r_sr;

endmodule
`default_nettype wire
